// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types.
// PC_W         : program-counter width used across the front end.
// pred_entry_t : one in-flight prediction record {pc, pred_pc}.
package riscv_pkg;

    localparam int unsigned PC_W = 48;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] pred_pc;
    } pred_entry_t;

endpackage

// File: rtl/pred_fifo.sv
// In-order FIFO of prediction entries awaiting resolution.
// Ports:
//   clk, n_reset     : clock, async active-low reset
//   push, push_data  : enqueue request and payload (dropped when full without pop)
//   pop              : dequeue request (ignored when empty)
//   flush            : discard all entries, overrides push and pop
//   head             : oldest entry, valid when empty is low
//   full, empty      : registered occupancy flags
module pred_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        push,
    input  pred_entry_t push_data,
    input  logic        pop,
    input  logic        flush,
    output pred_entry_t head,
    output logic        full,
    output logic        empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    pred_entry_t     mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic            do_push;
    logic            do_pop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rptr];

    // Next occupancy.
    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (do_push && !do_pop) begin
            count_nxt = count + CW'(1);
        end else if (do_pop && !do_push) begin
            count_nxt = count - CW'(1);
        end
    end

    // Pointers and flags; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (do_push) wptr <= wptr + AW'(1);
                if (do_pop)  rptr <= rptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage needs no reset; occupancy tracking guards every read.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wptr] <= push_data;
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// Resolves fetch-time predictions against execute results and redirects fetch.
// Ports:
//   clk, n_reset               : clock, async active-low reset
//   push, push_pc, push_pred_pc: prediction recorded by fetch
//   ex_valid, ex_pc, ex_next_pc: resolved control flow from execute
//   full                       : prediction FIFO holds DEPTH entries
//   mispred_ex                 : one-cycle redirect pulse
//   correct_pc_ex, index_pc_ex : redirect target and mispredicted pc (held)
//   err                        : sticky {order, underflow, overflow}
//   mispred_cnt                : saturating mispredict count
module branch_resolve #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PC_W  = riscv_pkg::PC_W
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic            push,
    input  logic [PC_W-1:0] push_pc,
    input  logic [PC_W-1:0] push_pred_pc,
    input  logic            ex_valid,
    input  logic [PC_W-1:0] ex_pc,
    input  logic [PC_W-1:0] ex_next_pc,
    output logic            full,
    output logic            mispred_ex,
    output logic [PC_W-1:0] correct_pc_ex,
    output logic [PC_W-1:0] index_pc_ex,
    output logic [2:0]      err,
    output logic [31:0]     mispred_cnt
);

    localparam int unsigned EW = riscv_pkg::PC_W;

    riscv_pkg::pred_entry_t push_entry;
    riscv_pkg::pred_entry_t head;
    logic                   empty;
    logic                   acc_push;
    logic                   acc_ex;
    logic                   do_pop;
    logic                   mispredict;
    logic                   order_err;
    logic                   underflow;
    logic                   overflow;

    assign push_entry = '{pc: EW'(push_pc), pred_pc: EW'(push_pred_pc)};

    // While the redirect pulse is out, fetch and execute are on the wrong path.
    assign acc_push   = push && !mispred_ex;
    assign acc_ex     = ex_valid && !mispred_ex;
    assign do_pop     = acc_ex && !empty;
    assign underflow  = acc_ex && empty;
    assign overflow   = acc_push && full && !do_pop;
    assign order_err  = do_pop && (head.pc != EW'(ex_pc));
    assign mispredict = do_pop && (head.pred_pc != EW'(ex_next_pc));

    pred_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .n_reset   (n_reset),
        .push      (acc_push),
        .push_data (push_entry),
        .pop       (do_pop),
        .flush     (mispredict),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // Redirect, training info, sticky errors and mispredict counter.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            mispred_ex    <= 1'b0;
            correct_pc_ex <= '0;
            index_pc_ex   <= '0;
            err           <= '0;
            mispred_cnt   <= '0;
        end else begin
            mispred_ex <= mispredict;
            err        <= err | {order_err, underflow, overflow};
            if (mispredict) begin
                correct_pc_ex <= ex_next_pc;
                index_pc_ex   <= ex_pc;
                if (mispred_cnt != 32'hFFFF_FFFF) begin
                    mispred_cnt <= mispred_cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: reference model plus redirect scoreboard.
module tb_branch_resolve;
    import riscv_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned PW    = 48;

    typedef struct packed {
        logic [PW-1:0] cpc;
        logic [PW-1:0] ipc;
    } redir_t;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          push;
    logic [PW-1:0] push_pc;
    logic [PW-1:0] push_pred_pc;
    logic          ex_valid;
    logic [PW-1:0] ex_pc;
    logic [PW-1:0] ex_next_pc;
    logic          full;
    logic          mispred_ex;
    logic [PW-1:0] correct_pc_ex;
    logic [PW-1:0] index_pc_ex;
    logic [2:0]    err;
    logic [31:0]   mispred_cnt;

    int checks = 0;
    int errors = 0;

    pred_entry_t mq[$];
    redir_t      exp_q[$];
    logic        m_misp;
    logic [2:0]  m_err;
    logic [31:0] m_cnt;
    logic [PW-1:0] m_cpc;
    logic [PW-1:0] m_ipc;

    branch_resolve #(.DEPTH(DEPTH), .PC_W(PW)) dut (
        .clk           (clk),
        .n_reset       (n_reset),
        .push          (push),
        .push_pc       (push_pc),
        .push_pred_pc  (push_pred_pc),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_next_pc    (ex_next_pc),
        .full          (full),
        .mispred_ex    (mispred_ex),
        .correct_pc_ex (correct_pc_ex),
        .index_pc_ex   (index_pc_ex),
        .err           (err),
        .mispred_cnt   (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_misp = 1'b0;
        m_err  = 3'b000;
        m_cnt  = 32'd0;
        m_cpc  = '0;
        m_ipc  = '0;
    endtask

    // Drive one cycle, advance the model, return at posedge+1.
    task automatic drive(input logic p, input logic [PW-1:0] ppc, input logic [PW-1:0] pred,
                         input logic ev, input logic [PW-1:0] epc, input logic [PW-1:0] enext);
        logic acc_push, acc_ex, misp_n;
        pred_entry_t h;
        push = p; push_pc = ppc; push_pred_pc = pred;
        ex_valid = ev; ex_pc = epc; ex_next_pc = enext;
        acc_push = p && !m_misp;
        acc_ex   = ev && !m_misp;
        misp_n   = 1'b0;
        if (acc_ex) begin
            if (mq.size() == 0) begin
                m_err[1] = 1'b1;
            end else begin
                h = mq.pop_front();
                if (h.pc != epc) m_err[2] = 1'b1;
                if (h.pred_pc != enext) begin
                    misp_n = 1'b1;
                    exp_q.push_back('{cpc: enext, ipc: epc});
                    m_cpc = enext;
                    m_ipc = epc;
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
                end
            end
        end
        if (acc_push && !misp_n) begin
            if (mq.size() < DEPTH) mq.push_back('{pc: ppc, pred_pc: pred});
            else m_err[0] = 1'b1;
        end
        if (misp_n) mq.delete();
        m_misp = misp_n;
        @(posedge clk);
        #1;
        push = 1'b0;
        ex_valid = 1'b0;
    endtask

    task automatic drain();
        int budget = 4 * DEPTH;
        while (mq.size() > 0 && budget > 0) begin
            drive(1'b0, '0, '0, 1'b1, mq[0].pc, mq[0].pred_pc);
            budget--;
        end
        if (mq.size() != 0) begin
            errors++;
            $display("FAIL drain_budget: %0d entries left, required 0", mq.size());
        end
        checks++;
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        push = 1'b0; ex_valid = 1'b0;
        push_pc = '0; push_pred_pc = '0; ex_pc = '0; ex_next_pc = '0;
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if ({full, mispred_ex, err} !== 5'b0 || mispred_cnt !== 32'd0 ||
            correct_pc_ex !== '0 || index_pc_ex !== '0) begin
            errors++;
            $display("FAIL reset_outputs: full=%b mispred=%b err=%b cnt=%0d cpc=%0h ipc=%0h, required all 0",
                     full, mispred_ex, err, mispred_cnt, correct_pc_ex, index_pc_ex);
        end
        checks++;
        if (int'(dut.u_fifo.count) != 0) begin
            errors++;
            $display("FAIL reset_count: got %0d required 0", dut.u_fifo.count);
        end
        n_reset = 1'b1;
    endtask

    task automatic test_match();
        drive(1'b1, 48'h100, 48'h104, 1'b0, '0, '0);
        drive(1'b0, '0, '0, 1'b1, 48'h100, 48'h104);
        checks++;
        if (mispred_ex !== 1'b0) begin
            errors++;
            $display("FAIL match_mispred: got %b required 0", mispred_ex);
        end
        checks++;
        if (int'(dut.u_fifo.count) != 0 || err !== 3'b000) begin
            errors++;
            $display("FAIL match_state: count=%0d err=%b required 0/000", dut.u_fifo.count, err);
        end
    endtask

    task automatic test_mispredict();
        redir_t r;
        drive(1'b1, 48'h200, 48'h204, 1'b0, '0, '0);
        drive(1'b1, 48'h204, 48'h208, 1'b0, '0, '0);
        drive(1'b0, '0, '0, 1'b1, 48'h200, 48'h300);
        checks++;
        if (mispred_ex !== 1'b1) begin
            errors++;
            $display("FAIL mispred_pulse: got %b required 1", mispred_ex);
        end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL mispred_scoreboard: no expected redirect queued");
        end else begin
            r = exp_q.pop_front();
            if (correct_pc_ex !== r.cpc || index_pc_ex !== r.ipc ||
                correct_pc_ex !== 48'h300 || index_pc_ex !== 48'h200) begin
                errors++;
                $display("FAIL mispred_target: cpc=%0h ipc=%0h required 300/200", correct_pc_ex, index_pc_ex);
            end
        end
        checks++;
        if (int'(dut.u_fifo.count) != 0 || mispred_cnt !== 32'd1) begin
            errors++;
            $display("FAIL mispred_flush: count=%0d cnt=%0d required 0/1", dut.u_fifo.count, mispred_cnt);
        end
        // Push and ex_valid during the pulse must both be ignored.
        drive(1'b1, 48'h600, 48'h604, 1'b1, 48'h700, 48'h704);
        checks++;
        if (mispred_ex !== 1'b0 || int'(dut.u_fifo.count) != 0 || err !== 3'b000) begin
            errors++;
            $display("FAIL mispred_ignore: mispred=%b count=%0d err=%b required 0/0/000",
                     mispred_ex, dut.u_fifo.count, err);
        end
        checks++;
        if (correct_pc_ex !== 48'h300 || index_pc_ex !== 48'h200) begin
            errors++;
            $display("FAIL mispred_hold: cpc=%0h ipc=%0h required 300/200", correct_pc_ex, index_pc_ex);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < int'(DEPTH); i++) begin
            drive(1'b1, 48'h1000 + PW'(i * 4), 48'h1004 + PW'(i * 4), 1'b0, '0, '0);
        end
        checks++;
        if (full !== 1'b1 || int'(dut.u_fifo.count) != int'(DEPTH)) begin
            errors++;
            $display("FAIL ovf_fill: full=%b count=%0d required 1/%0d", full, dut.u_fifo.count, DEPTH);
        end
        drive(1'b1, 48'h2000, 48'h2004, 1'b0, '0, '0);
        checks++;
        if (err !== 3'b001 || int'(dut.u_fifo.count) != int'(DEPTH) || full !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drop: err=%b count=%0d full=%b required 001/%0d/1", err, dut.u_fifo.count, full, DEPTH);
        end
        drive(1'b1, 48'h3000, 48'h3004, 1'b1, 48'h1000, 48'h1004);
        checks++;
        if (full !== 1'b1 || int'(dut.u_fifo.count) != int'(DEPTH) || err !== 3'b001 || mispred_ex !== 1'b0) begin
            errors++;
            $display("FAIL ovf_pushpop: full=%b count=%0d err=%b mispred=%b required 1/%0d/001/0",
                     full, dut.u_fifo.count, err, mispred_ex, DEPTH);
        end
        drain();
        checks++;
        if (full !== 1'b0 || int'(dut.u_fifo.count) != 0 || err !== 3'b001) begin
            errors++;
            $display("FAIL ovf_drain: full=%b count=%0d err=%b required 0/0/001", full, dut.u_fifo.count, err);
        end
    endtask

    task automatic test_underflow();
        drive(1'b1, 48'h500, 48'h504, 1'b1, 48'h500, 48'h504);
        checks++;
        if (err !== 3'b011 || int'(dut.u_fifo.count) != 1 || mispred_ex !== 1'b0) begin
            errors++;
            $display("FAIL underflow: err=%b count=%0d mispred=%b required 011/1/0", err, dut.u_fifo.count, mispred_ex);
        end
        drain();
    endtask

    task automatic test_order();
        drive(1'b1, 48'h400, 48'h404, 1'b0, '0, '0);
        drive(1'b0, '0, '0, 1'b1, 48'h404, 48'h404);
        checks++;
        if (err !== 3'b111 || mispred_ex !== 1'b0 || int'(dut.u_fifo.count) != 0) begin
            errors++;
            $display("FAIL order: err=%b mispred=%b count=%0d required 111/0/0", err, mispred_ex, dut.u_fifo.count);
        end
    endtask

    task automatic test_back_to_back();
        redir_t r;
        logic p, ev;
        logic [PW-1:0] ppc, epc, enext;
        for (int i = 0; i < 80; i++) begin
            p   = ($urandom_range(0, 3) != 0);
            ppc = PW'(48'h8000 + PW'(i * 4));
            ev  = 1'b0; epc = '0; enext = '0;
            if (mq.size() > 0 && $urandom_range(0, 2) != 0) begin
                ev    = 1'b1;
                epc   = mq[0].pc;
                enext = ($urandom_range(0, 4) == 0) ? mq[0].pred_pc + PW'(8) : mq[0].pred_pc;
            end
            drive(p, ppc, ppc + PW'(4), ev, epc, enext);
            checks++;
            if (mispred_ex !== m_misp || int'(dut.u_fifo.count) != mq.size() ||
                full !== (mq.size() == DEPTH) || err !== m_err || mispred_cnt !== m_cnt) begin
                errors++;
                $display("FAIL b2b_state[%0d]: mispred=%b/%b count=%0d/%0d err=%b/%b cnt=%0d/%0d (got/required)",
                         i, mispred_ex, m_misp, dut.u_fifo.count, mq.size(), err, m_err, mispred_cnt, m_cnt);
            end
            if (mispred_ex === 1'b1 && exp_q.size() > 0) begin
                r = exp_q.pop_front();
                checks++;
                if (correct_pc_ex !== r.cpc || index_pc_ex !== r.ipc) begin
                    errors++;
                    $display("FAIL b2b_redirect[%0d]: cpc=%0h ipc=%0h required %0h/%0h",
                             i, correct_pc_ex, index_pc_ex, r.cpc, r.ipc);
                end
            end else if (mispred_ex !== 1'b1) begin
                checks++;
                if (correct_pc_ex !== m_cpc || index_pc_ex !== m_ipc) begin
                    errors++;
                    $display("FAIL b2b_hold[%0d]: cpc=%0h ipc=%0h required %0h/%0h",
                             i, correct_pc_ex, index_pc_ex, m_cpc, m_ipc);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_scoreboard: %0d redirects never seen, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 48'h900 + PW'(i * 4), 48'h904 + PW'(i * 4), 1'b0, '0, '0);
        end
        #2;
        n_reset = 1'b0;
        #1;
        checks++;
        if (int'(dut.u_fifo.count) != 0 || full !== 1'b0 || err !== 3'b000 || mispred_cnt !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_queued: count=%0d full=%b err=%b cnt=%0d required 0", dut.u_fifo.count, full, err, mispred_cnt);
        end
        model_reset();
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        drive(1'b1, 48'hA00, 48'hA04, 1'b0, '0, '0);
        checks++;
        if (int'(dut.u_fifo.count) != 1) begin
            errors++;
            $display("FAIL rst_first_push: count=%0d required 1", dut.u_fifo.count);
        end
        drive(1'b1, 48'hA04, 48'hA08, 1'b0, '0, '0);
        drive(1'b0, '0, '0, 1'b1, 48'hA00, 48'hB00);
        checks++;
        if (mispred_ex !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_setup: mispred=%b required 1", mispred_ex);
        end
        #2;
        n_reset = 1'b0;
        #1;
        checks++;
        if (mispred_ex !== 1'b0 || correct_pc_ex !== '0 || index_pc_ex !== '0 ||
            mispred_cnt !== 32'd0 || err !== 3'b000 || int'(dut.u_fifo.count) != 0) begin
            errors++;
            $display("FAIL rst_mid_mispred: mispred=%b cpc=%0h ipc=%0h cnt=%0d err=%b count=%0d required all 0",
                     mispred_ex, correct_pc_ex, index_pc_ex, mispred_cnt, err, dut.u_fifo.count);
        end
        model_reset();
        @(posedge clk);
        #1;
        n_reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_match();
        test_mispredict();
        test_overflow();
        test_underflow();
        test_order();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of in-flight prediction entries (power of two, 2..32).
REQ-002 SHALL have parameter PC_W, default 48, program-counter width.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port n_reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port push, input, 1, fetch stage accepted an instruction this cycle (its ready and valid fetch are both high).
REQ-006 SHALL have port push_pc, input, PC_W, pc of the fetched instruction.
REQ-007 SHALL have port push_pred_pc, input, PC_W, next pc chosen by fetch: pred_pc when predictor valid, else pc+4.
REQ-008 SHALL have port ex_valid, input, 1, execute retires one control-flow-resolved instruction this cycle.
REQ-009 SHALL have port ex_pc, input, PC_W, pc of the resolving instruction.
REQ-010 SHALL have port ex_next_pc, input, PC_W, architecturally correct next pc.
REQ-011 SHALL have port full, output, 1, FIFO holds DEPTH entries.
REQ-012 SHALL have port mispred_ex, output, 1, redirect pulse to fetch.
REQ-013 SHALL have port correct_pc_ex, output, PC_W, redirect target.
REQ-014 SHALL have port index_pc_ex, output, PC_W, pc of the mispredicted instruction, for predictor training.
REQ-015 SHALL have port err, output, 3, sticky flags {order, underflow, overflow}.
REQ-016 SHALL have port mispred_cnt, output, 32, saturating mispredict count.

Function
REQ-017 SHALL store {push_pc, push_pred_pc} in an in-order FIFO on each accepted push.
REQ-018 SHALL pop the head entry on ex_valid when the FIFO is non-empty.
REQ-019 SHALL set err[2] (order) when a popped head pc differs from ex_pc, and SHALL still compare pred_pc.
REQ-020 SHALL, when the popped head pred_pc differs from ex_next_pc, drive mispred_ex high on the next cycle for exactly one cycle, with correct_pc_ex=ex_next_pc and index_pc_ex=ex_pc registered on the same edge.
REQ-021 SHALL hold correct_pc_ex and index_pc_ex stable until the next mispredict.
REQ-022 SHALL flush the FIFO on the mispredict-detect edge, discarding all entries including any push in that cycle.
REQ-023 SHALL ignore push while mispred_ex is high, because fetch is being redirected.
REQ-024 SHALL ignore ex_valid while mispred_ex is high, because those are wrong-path instructions.
REQ-025 SHALL ignore ex_valid on an empty FIFO and set err[1] (underflow); a same-cycle push is not bypassed.
REQ-026 SHALL drop a push when full with no pop that cycle, and set err[0] (overflow).
REQ-027 SHALL accept a simultaneous push and pop while full, keeping the count unchanged.
REQ-028 SHALL wrap read/write pointers modulo DEPTH and derive full/empty from a count of width clog2(DEPTH)+1.
REQ-029 SHALL increment mispred_cnt once per mispredict and saturate at 0xFFFFFFFF.
REQ-030 SHALL make the latency from ex_valid to mispred_ex exactly 1 cycle.

Reset
REQ-031 SHALL, on n_reset low at any time including mid-operation, asynchronously clear the FIFO to empty, full=0, mispred_ex=0, correct_pc_ex=0, index_pc_ex=0, err=0, mispred_cnt=0.
REQ-032 SHALL process the first push on the first rising edge after n_reset deasserts.

Structure
REQ-033 SHALL take PC_W and the pred_entry_t struct {pc, pred_pc} from the shared riscv package.
REQ-034 SHALL implement storage as one sub-module, pred_fifo, providing push, pop, flush, full, empty and head ports.
REQ-035 SHALL keep the compare, redirect and counter logic in branch_resolve.

Verification
REQ-036 Bench SHALL cover: push {0x100, 0x104}, then ex_valid with ex_pc=0x100, ex_next_pc=0x104 -> no mispred_ex, FIFO empty.
REQ-037 Bench SHALL cover: push {0x200, 0x204} and {0x204, 0x208}, then ex_valid with ex_pc=0x200, ex_next_pc=0x300 -> next cycle mispred_ex=1 for one cycle, correct_pc_ex=0x300, index_pc_ex=0x200, FIFO empty, mispred_cnt=1.
REQ-038 Bench SHALL cover: 8 pushes, then a 9th push with no pop -> entry dropped, err=3'b001; then push and pop in the same cycle -> full stays 1.
REQ-039 Bench SHALL cover: ex_valid on an empty FIFO with a same-cycle push -> err[1]=1, FIFO count=1.
REQ-040 Bench SHALL cover: head pc 0x400 with ex_pc=0x404 and matching pred -> err[2]=1, no mispred_ex.
REQ-041 Bench SHALL cover: n_reset pulsed low with 5 entries queued and mispred_ex high -> all outputs 0 and FIFO empty immediately.
